// File: rtl/lcd_msg_scheduler_pkg.sv
// Shared types and constants for the two-requester LCD message scheduler.
package lcd_msg_scheduler_pkg;

  localparam int unsigned LINE_W          = 128;
  localparam int unsigned DEFAULT_DWELL   = 50_000_000;
  localparam int unsigned DEFAULT_TIMEOUT = 200_000_000;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    START,
    WAIT_DONE,
    DWELL
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// Scheduler-to-LCD-writer link: latched text plus start/busy/done handshake.
interface lcd_msg_scheduler_if;

  logic [lcd_msg_scheduler_pkg::LINE_W-1:0] line1;
  logic [lcd_msg_scheduler_pkg::LINE_W-1:0] line2;
  logic                                     wr_start;
  logic                                     wr_busy;
  logic                                     wr_done;

  modport master (output line1, line2, wr_start, input wr_busy, wr_done);
  modport slave  (input line1, line2, wr_start, output wr_busy, wr_done);

endinterface

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module lcd_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio;  // 0: requester 0 wins a tie, 1: requester 1 wins a tie

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prio <= 1'b0;
    else if (advance && (gnt != 2'b00))
      prio <= gnt[0];
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Grants one of two message sources, hands its two lines to the LCD writer,
// waits for completion (with timeout) and holds the text for a dwell period.
module lcd_msg_scheduler
  import lcd_msg_scheduler_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES   = DEFAULT_DWELL,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [LINE_W-1:0]  msg0_l1,
  input  logic [LINE_W-1:0]  msg0_l2,
  input  logic [LINE_W-1:0]  msg1_l1,
  input  logic [LINE_W-1:0]  msg1_l2,
  output logic [1:0]         gnt,
  output logic               active_id,
  output logic               busy,
  output logic               err,
  lcd_msg_scheduler_if.master lcd
);

  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] DWELL_LAST   = (DWELL_CYCLES == 0)   ? 32'd0 : 32'(DWELL_CYCLES - 1);

  state_t      state;
  logic [31:0] cnt;
  logic [1:0]  arb_gnt;

  lcd_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (state == LATCH),
    .gnt     (arb_gnt)
  );

  assign busy = (state != IDLE);

  // NOTE: the wide line registers are plain flops, so they take the async reset like the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt          <= '0;
      active_id    <= 1'b0;
      err          <= 1'b0;
      lcd.line1    <= '0;
      lcd.line2    <= '0;
      lcd.wr_start <= 1'b0;
    end else begin
      gnt          <= '0;
      lcd.wr_start <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (req != 2'b00) state <= LATCH;
        end
        LATCH: begin
          // A request withdrawn before the latch cycle is dropped silently.
          if (req != 2'b00) begin
            gnt       <= arb_gnt;
            active_id <= arb_gnt[1];
            lcd.line1 <= arb_gnt[1] ? msg1_l1 : msg0_l1;
            lcd.line2 <= arb_gnt[1] ? msg1_l2 : msg0_l2;
            state     <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (!lcd.wr_busy) begin
            lcd.wr_start <= 1'b1;
            cnt          <= '0;
            state        <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (lcd.wr_done) begin
            cnt   <= '0;
            state <= (DWELL_CYCLES == 0) ? IDLE : DWELL;
          end else if (cnt >= TIMEOUT_LAST) begin
            err   <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        DWELL: begin
          if (cnt >= DWELL_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Self-checking bench: scoreboarded grants/lines on a DWELL=4 instance, plus a
// DWELL=0 instance for back-to-back service.
module tb_lcd_msg_scheduler;
  import lcd_msg_scheduler_pkg::*;

  typedef struct {
    logic [1:0]        gnt;
    logic [LINE_W-1:0] l1;
    logic [LINE_W-1:0] l2;
  } exp_t;

  localparam int WR_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  logic [LINE_W-1:0] m0l1, m0l2, m1l1, m1l2;

  logic [1:0] req_a, gnt_a;
  logic       active_a, busy_a, err_a;
  logic [1:0] req_b, gnt_b;
  logic       active_b, busy_b, err_b;

  lcd_msg_scheduler_if ifa ();
  lcd_msg_scheduler_if ifb ();

  lcd_msg_scheduler #(.DWELL_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .req(req_a),
    .msg0_l1(m0l1), .msg0_l2(m0l2), .msg1_l1(m1l1), .msg1_l2(m1l2),
    .gnt(gnt_a), .active_id(active_a), .busy(busy_a), .err(err_a), .lcd(ifa)
  );

  lcd_msg_scheduler #(.DWELL_CYCLES(0), .TIMEOUT_CYCLES(100)) dut0 (
    .clk(clk), .rst(rst), .req(req_b),
    .msg0_l1(m0l1), .msg0_l2(m0l2), .msg1_l1(m1l1), .msg1_l2(m1l2),
    .gnt(gnt_b), .active_id(active_b), .busy(busy_b), .err(err_b), .lcd(ifb)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  logic model_prio;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] pend, input logic prio);
    if (pend == 2'b11) return prio ? 2'b10 : 2'b01;
    return pend;
  endfunction

  // Queue the grants expected for the pending set, in round-robin order.
  task automatic push_pending(input logic [1:0] pend);
    logic [1:0] pick;
    exp_t e;
    while (pend != 2'b00) begin
      pick  = rr_pick(pend, model_prio);
      e.gnt = pick;
      e.l1  = pick[1] ? m1l1 : m0l1;
      e.l2  = pick[1] ? m1l2 : m0l2;
      sb.push_back(e);
      model_prio = pick[0];
      pend &= ~pick;
    end
  endtask

  // Writer models: pulse wr_done WR_LAT cycles after wr_start unless muted.
  logic mute_a = 1'b0;
  int   wcnt_a = 0, wcnt_b = 0, ws_count_a = 0;
  time  done_time_a = 0, done_time_b = 0;

  always @(negedge clk) begin
    ifa.wr_done = 1'b0;
    if (wcnt_a > 0) begin
      wcnt_a--;
      if (wcnt_a == 0) begin ifa.wr_done = 1'b1; done_time_a = $time; end
    end
    if (ifa.wr_start) begin
      ws_count_a++;
      if (!mute_a) wcnt_a = WR_LAT;
    end
  end

  always @(negedge clk) begin
    ifb.wr_done = 1'b0;
    if (wcnt_b > 0) begin
      wcnt_b--;
      if (wcnt_b == 0) begin ifb.wr_done = 1'b1; done_time_b = $time; end
    end
    if (ifb.wr_start) wcnt_b = WR_LAT;
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && gnt_a != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_gnt", gnt_a, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_gnt", gnt_a, mon_e.gnt);
        check("sb_line1", ifa.line1, mon_e.l1);
        check("sb_line2", ifa.line2, mon_e.l2);
        check("sb_active_id", active_a, mon_e.gnt[1]);
      end
    end
  end

  task automatic wait_gnt(input int budget, output logic [1:0] g, output logic [LINE_W-1:0] last_l1);
    g = '0;
    last_l1 = ifa.line1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt_a != 2'b00) begin g = gnt_a; return; end
      last_l1 = ifa.line1;
    end
    check("wait_gnt_timeout", 1, 0);
  endtask

  task automatic wait_ws(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifa.wr_start) return;
    end
    check("wait_wr_start_timeout", 1, 0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_a) return;
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  logic [1:0]        g;
  logic [LINE_W-1:0] l1_before;
  int                ws0;
  time               t_g;

  initial begin
    m0l1 = "HELLO WORLD     ";
    m0l2 = "REQUESTER ZERO  ";
    m1l1 = "STATUS: OK      ";
    m1l2 = "REQUESTER ONE   ";
    rst = 1'b1; req_a = '0; req_b = '0;
    ifa.wr_busy = 1'b0; ifb.wr_busy = 1'b0;
    ifa.wr_done = 1'b0; ifb.wr_done = 1'b0;
    model_prio = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt_a, 0);
    check("rst_wr_start", ifa.wr_start, 0);
    check("rst_line1", ifa.line1, 0);
    check("rst_line2", ifa.line2, 0);
    check("rst_active_id", active_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_err", err_a, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Both requesters pending: 01 then 10, text held through the dwell.
    push_pending(2'b11);
    req_a = 2'b11;
    wait_gnt(20, g, l1_before);
    check("rr_first", g, 2'b01);
    req_a &= ~g;
    wait_gnt(40, g, l1_before);
    t_g = $time;
    check("rr_second", g, 2'b10);
    check("line1_held_in_dwell", l1_before, m0l1);
    check("dwell_gap", int'((t_g - done_time_a) / 10), 7);
    req_a &= ~g;
    wait_idle(40);

    // Minimum latency: LATCH after one edge, gnt on the second, wr_start on the third.
    push_pending(2'b01);
    ws0 = ws_count_a;
    req_a = 2'b01;
    @(negedge clk);
    check("lat_busy_c1", busy_a, 1);
    check("lat_gnt_c1", gnt_a, 0);
    @(negedge clk);
    check("lat_gnt_c2", gnt_a, 2'b01);
    req_a = 2'b00;
    @(negedge clk);
    check("lat_wr_start_c3", ifa.wr_start, 1);
    wait_idle(40);
    check("lat_ws_once", ws_count_a - ws0, 1);

    // Writer busy holds off wr_start, which then pulses exactly once.
    ifa.wr_busy = 1'b1;
    push_pending(2'b01);
    req_a = 2'b01;
    wait_gnt(20, g, l1_before);
    req_a = 2'b00;
    ws0 = ws_count_a;
    repeat (10) @(negedge clk);
    check("busy_holds_start", ws_count_a - ws0, 0);
    ifa.wr_busy = 1'b0;
    @(negedge clk);
    check("start_after_busy", ifa.wr_start, 1);
    wait_idle(40);
    check("busy_ws_once", ws_count_a - ws0, 1);

    // Timeout: err sets on WAIT_DONE cycle 100 and sticks; service continues.
    mute_a = 1'b1;
    push_pending(2'b10);
    req_a = 2'b10;
    wait_gnt(20, g, l1_before);
    req_a = 2'b00;
    wait_ws(20);
    repeat (99) @(negedge clk);
    check("err_before_timeout", err_a, 0);
    @(negedge clk);
    check("err_at_timeout", err_a, 1);
    check("idle_at_timeout", busy_a, 0);
    mute_a = 1'b0;
    push_pending(2'b01);
    req_a = 2'b01;
    wait_gnt(20, g, l1_before);
    req_a = 2'b00;
    wait_idle(40);
    check("err_sticky", err_a, 1);

    // Reset mid-WAIT_DONE: immediate clear, clean restart, pointer back to 0.
    push_pending(2'b01);
    req_a = 2'b01;
    wait_gnt(20, g, l1_before);
    req_a = 2'b00;
    wait_ws(20);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_start", ifa.wr_start, 0);
    check("mid_rst_line1", ifa.line1, 0);
    check("mid_rst_line2", ifa.line2, 0);
    check("mid_rst_active_id", active_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_err", err_a, 0);
    model_prio = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ws0 = ws_count_a;
    repeat (5) @(negedge clk);
    check("no_spurious_start", ws_count_a - ws0, 0);
    push_pending(2'b10);
    req_a = 2'b10;
    wait_gnt(20, g, l1_before);
    check("post_rst_gnt1", g, 2'b10);
    req_a = 2'b00;
    wait_idle(40);
    push_pending(2'b11);
    req_a = 2'b11;
    wait_gnt(20, g, l1_before);
    req_a &= ~g;
    wait_gnt(40, g, l1_before);
    req_a &= ~g;
    wait_idle(40);

    // Zero dwell: continuous requests are served back to back via IDLE only.
    req_b = 2'b01;
    for (int r = 0; r < 3; r++) begin
      g = '0;
      for (int i = 0; i < 30 && g == 2'b00; i++) begin
        @(negedge clk);
        g = gnt_b;
      end
      t_g = $time;
      check("b2b_gnt", g, 2'b01);
      check("b2b_line1", ifb.line1, m0l1);
      if (r > 0) check("b2b_gap", int'((t_g - done_time_b) / 10), 3);
    end
    req_b = 2'b00;
    repeat (10) @(negedge clk);
    check("b2b_idle", busy_b, 0);
    check("b2b_err", err_b, 0);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_msg_scheduler.md
LCD_MSG_SCHEDULER -- requirements
Module: lcd_msg_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 50000000: minimum clk cycles a completed message stays displayed before the next grant.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000000: maximum clk cycles to wait for wr_done before aborting.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, 2 bits: per-requester message-pending level, held until that requester's gnt.
REQ-006 SHALL have ports msg0_l1, msg0_l2, msg1_l1, msg1_l2, input, 128 bits each: 16-char ASCII lines per requester, MSB = first char.
REQ-007 SHALL have port gnt, output, 2 bits: one-hot, one-cycle pulse marking the requester whose message was latched.
REQ-008 SHALL have ports line1, line2, output, 128 bits each: latched message to the LCD writer, stable from latch until the next latch.
REQ-009 SHALL have port wr_start, output, 1 bit: one-cycle pulse that starts the LCD writer.
REQ-010 SHALL have ports wr_busy and wr_done, input, 1 bit each: writer busy level, and completion pulse.
REQ-011 SHALL have ports active_id (1 bit, owner of current message), busy (1 bit, high whenever state is not IDLE) and err (1 bit, sticky timeout flag), all outputs.

Function
REQ-012 SHALL implement the states IDLE, LATCH, START, WAIT_DONE and DWELL.
REQ-013 IDLE: when any req bit is high, SHALL go to LATCH the next cycle.
REQ-014 LATCH: SHALL pick the winner by round-robin, latch its lines into line1/line2, set active_id, pulse gnt for exactly this cycle, then go to START.
REQ-015 Round-robin rule: with both req high, SHALL grant the requester not granted last; the pointer after reset SHALL favour requester 0.
REQ-016 If req drops between IDLE and LATCH, SHALL return to IDLE with no gnt.
REQ-017 START: SHALL wait while wr_busy=1, then pulse wr_start for one cycle and go to WAIT_DONE.
REQ-018 WAIT_DONE: on wr_done=1 SHALL go to DWELL; wr_done in any other state SHALL be ignored.
REQ-019 WAIT_DONE timeout: if TIMEOUT_CYCLES elapse without wr_done, SHALL set err and go to IDLE; err SHALL clear only on reset.
REQ-020 DWELL: SHALL count DWELL_CYCLES cycles then go to IDLE; with DWELL_CYCLES=0 it SHALL go straight to IDLE.
REQ-021 A single 32-bit counter SHALL be shared by WAIT_DONE and DWELL, cleared on each state entry, and SHALL saturate rather than wrap.
REQ-022 New req assertions during START, WAIT_DONE or DWELL SHALL be held pending and SHALL NOT alter line1/line2.
REQ-023 Minimum latency from req to wr_start with wr_busy=0 SHALL be 3 cycles: IDLE, LATCH, START.

Reset
REQ-024 rst SHALL force state IDLE, gnt=0, wr_start=0, line1=line2=0, active_id=0, busy=0, err=0, counter=0 and the round-robin pointer to favour requester 0.
REQ-025 rst asserted mid-operation SHALL abort immediately; after release the block SHALL resume from IDLE with no spurious wr_start.

Structure
REQ-026 A shared package SHALL hold LINE_W=128, the state enumeration and the default DWELL/TIMEOUT constants.
REQ-027 The 2-way round-robin selection with its pointer SHALL be a sub-module, lcd_rr_arb.

Verification
REQ-028 With req=01, msg0_l1="HELLO..." and wr_busy=0: gnt=01 on cycle 2, wr_start on cycle 3, line1=msg0_l1.
REQ-029 With req=11 held over two rounds: gnt order 01 then 10; line1 switches only after DWELL completes.
REQ-030 With wr_busy=1 for 10 cycles during START: wr_start is delayed until the first cycle wr_busy=0, and pulses exactly once.
REQ-031 With wr_done never asserted and TIMEOUT_CYCLES=100: err=1 at cycle 100 of WAIT_DONE, state IDLE; the next req is still served.
REQ-032 With rst pulsed during WAIT_DONE: all outputs read 0 immediately, and a later req=10 is granted to requester 1 with pointer behaviour per REQ-015.
REQ-033 With DWELL_CYCLES=0 and continuous req=01: back-to-back grants, with no DWELL cycles between wr_done and the next LATCH other than IDLE.
